// File: rtl/prog_loader_if.sv
// Host/CPU-side bundle for prog_loader: load controls, write strobe, fetch port and status.
interface prog_loader_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic              ena;
  logic              load_mode;
  logic              wr_strobe;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_run;
  logic [AW-1:0]     load_addr;
  logic              load_done;
  logic              overflow;

  modport master (
    output ena, load_mode, wr_strobe, wr_data, fetch_addr,
    input  fetch_data, cpu_run, load_addr, load_done, overflow
  );

  modport slave (
    input  ena, load_mode, wr_strobe, wr_data, fetch_addr,
    output fetch_data, cpu_run, load_addr, load_done, overflow
  );
endinterface

// File: rtl/prog_loader.sv
// Program memory loader: synchronizes an external write strobe, fills DEPTH words
// while in LOAD, then hands the memory to the CPU fetch port in RUN.
module prog_loader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              sync1;
  logic              sync2;
  logic              hist;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     load_addr;
  logic              load_done;
  logic              overflow;

  logic strobe_edge_c;
  logic enter_load_c;
  logic in_load_c;
  logic wr_en_c;
  logic ovf_set_c;

  // Strobe synchronizer runs free of ena and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= bus.wr_strobe;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign strobe_edge_c = sync2 & ~hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.ena) begin
      case (state)
        ST_IDLE: state_nxt = bus.load_mode ? ST_LOAD : ST_RUN;
        ST_LOAD: if (!bus.load_mode) state_nxt = ST_RUN;
        ST_RUN:  if (bus.load_mode)  state_nxt = ST_LOAD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // state_nxt only moves under ena, so entry detection is already gated
  assign enter_load_c = (state_nxt == ST_LOAD) && (state != ST_LOAD);
  assign in_load_c    = bus.ena && (state == ST_LOAD);
  assign wr_en_c      = in_load_c && strobe_edge_c && !load_done;
  assign ovf_set_c    = in_load_c && strobe_edge_c && load_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_addr <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (enter_load_c) begin
      load_addr <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (wr_en_c) begin
      load_addr <= load_addr + AW'(1);
      if (load_addr == AW'(DEPTH - 1)) load_done <= 1'b1;
    end else if (ovf_set_c) begin
      overflow <= 1'b1;
    end
  end

  // Reset clears every word so a reset mid-load leaves no partial program
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      mem[load_addr] <= bus.wr_data;
    end
  end

  assign bus.fetch_data = mem[bus.fetch_addr];
  assign bus.cpu_run    = (state == ST_RUN) && bus.ena;
  assign bus.load_addr  = load_addr;
  assign bus.load_done  = load_done;
  assign bus.overflow   = overflow;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load/run sequencing, write latency, wrap, overflow, reset.
module tb_prog_loader;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  prog_loader_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  prog_loader #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe high for three edges (write lands on the third), then low long enough to re-arm
  task automatic send_word(input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.wr_data   = d;
    bus.wr_strobe = 1'b1;
    repeat (3) @(negedge clk);
    bus.wr_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_word(input int unsigned a, input logic [DATA_W-1:0] exp, input string tag);
    bus.fetch_addr = AW'(a);
    #1;
    check_eq(tag, 32'(bus.fetch_data), 32'(exp));
  endtask

  initial begin
    bus.ena        = 1'b0;
    bus.load_mode  = 1'b0;
    bus.wr_strobe  = 1'b0;
    bus.wr_data    = '0;
    bus.fetch_addr = '0;
    rst_n          = 1'b0;

    #1;
    check_eq("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("rst_fetch", 32'(bus.fetch_data), 32'd0);
    check_eq("rst_load_addr", 32'(bus.load_addr), 32'd0);
    check_eq("rst_done", 32'(bus.load_done), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("post_rst_fetch", 32'(bus.fetch_data), 32'd0);

    // Enter LOAD
    bus.ena       = 1'b1;
    bus.load_mode = 1'b1;
    @(negedge clk);
    check_eq("load_cpu_run", 32'(bus.cpu_run), 32'd0);

    // First word with per-edge latency check
    bus.fetch_addr = '0;
    @(negedge clk);
    bus.wr_data   = 8'hA1;
    bus.wr_strobe = 1'b1;
    @(negedge clk);
    check_eq("a1_edge1_data", 32'(bus.fetch_data), 32'd0);
    check_eq("a1_edge1_addr", 32'(bus.load_addr), 32'd0);
    @(negedge clk);
    check_eq("a1_edge2_data", 32'(bus.fetch_data), 32'd0);
    check_eq("a1_edge2_addr", 32'(bus.load_addr), 32'd0);
    @(negedge clk);
    check_eq("a1_edge3_data", 32'(bus.fetch_data), 32'hA1);
    check_eq("a1_edge3_addr", 32'(bus.load_addr), 32'd1);
    bus.wr_strobe = 1'b0;
    repeat (3) @(negedge clk);
    send_word(8'hB2);
    send_word(8'hC3);
    check_eq("abc_load_addr", 32'(bus.load_addr), 32'd3);
    check_eq("abc_cpu_run", 32'(bus.cpu_run), 32'd0);
    read_word(0, 8'hA1, "mem0_a1");
    read_word(1, 8'hB2, "mem1_b2");
    read_word(2, 8'hC3, "mem2_c3");

    // Pass through RUN and re-enter LOAD: pointer and flags restart
    @(negedge clk);
    bus.load_mode = 1'b0;
    @(negedge clk);
    check_eq("run_after_fall", 32'(bus.cpu_run), 32'd1);
    bus.load_mode = 1'b1;
    @(negedge clk);
    check_eq("reload_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("reload_addr", 32'(bus.load_addr), 32'd0);

    // Full fill and wrap
    for (int i = 0; i < 16; i++) begin
      send_word(DATA_W'(i));
      if (i == 14) check_eq("done_before_wrap", 32'(bus.load_done), 32'd0);
      if (i == 15) begin
        check_eq("done_on_wrap", 32'(bus.load_done), 32'd1);
        check_eq("addr_wrapped", 32'(bus.load_addr), 32'd0);
        check_eq("ovf_at_wrap", 32'(bus.overflow), 32'd0);
      end
    end
    send_word(8'hFF);
    check_eq("ovf_set", 32'(bus.overflow), 32'd1);
    check_eq("ovf_addr", 32'(bus.load_addr), 32'd0);
    read_word(0, 8'h00, "ovf_mem0_kept");

    // Hand over to CPU
    @(negedge clk);
    bus.load_mode = 1'b0;
    #1;
    check_eq("fall_same_cycle", 32'(bus.cpu_run), 32'd0);
    @(negedge clk);
    check_eq("run_one_edge_later", 32'(bus.cpu_run), 32'd1);
    for (int i = 0; i < 16; i++) read_word(i, DATA_W'(i), "sweep");

    // Strobe in RUN is ignored
    send_word(8'hEE);
    read_word(0, 8'h00, "run_strobe_mem0");
    check_eq("run_strobe_addr", 32'(bus.load_addr), 32'd0);
    check_eq("run_strobe_done", 32'(bus.load_done), 32'd1);
    check_eq("run_strobe_ovf", 32'(bus.overflow), 32'd1);
    check_eq("run_strobe_cpu_run", 32'(bus.cpu_run), 32'd1);

    // ena low freezes the FSM even with a LOAD request pending
    @(negedge clk);
    bus.ena = 1'b0;
    #1;
    check_eq("ena0_cpu_run", 32'(bus.cpu_run), 32'd0);
    bus.load_mode = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("ena0_ovf_held", 32'(bus.overflow), 32'd1);
    check_eq("ena0_done_held", 32'(bus.load_done), 32'd1);
    bus.ena = 1'b1;
    #1;
    check_eq("ena1_cpu_run", 32'(bus.cpu_run), 32'd1);
    @(negedge clk);
    check_eq("relo_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("relo_addr", 32'(bus.load_addr), 32'd0);
    check_eq("relo_done", 32'(bus.load_done), 32'd0);
    check_eq("relo_ovf", 32'(bus.overflow), 32'd0);

    // Strobe edge coincident with load_mode fall
    bus.fetch_addr = '0;
    @(negedge clk);
    bus.wr_data   = 8'h5A;
    bus.wr_strobe = 1'b1;
    repeat (2) @(negedge clk);
    bus.load_mode = 1'b0;
    #1;
    check_eq("coinc_pre_cpu_run", 32'(bus.cpu_run), 32'd0);
    @(negedge clk);
    check_eq("coinc_cpu_run", 32'(bus.cpu_run), 32'd1);
    check_eq("coinc_addr", 32'(bus.load_addr), 32'd1);
    check_eq("coinc_data", 32'(bus.fetch_data), 32'h5A);
    bus.wr_strobe = 1'b0;
    repeat (3) @(negedge clk);

    // Reload five words, then reset mid-sequence
    bus.load_mode = 1'b1;
    @(negedge clk);
    check_eq("r5_start_addr", 32'(bus.load_addr), 32'd0);
    for (int i = 0; i < 5; i++) send_word(DATA_W'(8'h11 + i));
    check_eq("r5_addr", 32'(bus.load_addr), 32'd5);
    read_word(4, 8'h15, "r5_mem4");
    @(negedge clk);
    bus.wr_data   = 8'h66;
    bus.wr_strobe = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("midrst_addr", 32'(bus.load_addr), 32'd0);
    check_eq("midrst_done", 32'(bus.load_done), 32'd0);
    for (int i = 0; i < 16; i++) read_word(i, 8'h00, "midrst_mem");
    bus.wr_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_rel_cpu_run", 32'(bus.cpu_run), 32'd0);
    read_word(0, 8'h00, "midrst_rel_mem0");
    repeat (4) @(negedge clk);
    check_eq("midrst_final_cpu_run", 32'(bus.cpu_run), 32'd0);
    read_word(4, 8'h00, "midrst_final_mem4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
